sodor_imem_feed_ctrl: RTL and testbench

Instruction-feed sequencer for the sodor5 core's imem response path. It holds a small program buffer that is loaded over a write port. On start, it replays the buffer into the core under a valid/ready handshake, repeating it a programmable number of times, then emits a fixed number of NOPs to drain the 5-stage pipeline and signals done. While idle and during reset it presents the canonical NOP (addi x0,x0,0).

---
 rtl/sodor_feed_pkg.sv | 17 +
 rtl/sodor_feed_prog_mem.sv | 26 ++
 rtl/sodor_imem_feed_ctrl.sv | 149 ++++++++++++++
 tb/tb_sodor_imem_feed_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sodor_feed_pkg.sv
// Shared types and constants for the sodor5 imem instruction-feed sequencer.
package sodor_feed_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 4;

    // Canonical RISC-V NOP: addi x0, x0, 0
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sodor_feed_prog_mem.sv
// Program buffer for the instruction-feed sequencer: synchronous write, asynchronous read.
module sodor_feed_prog_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = sodor_feed_pkg::ADDR_W,
    parameter int unsigned WORD_W = sodor_feed_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    // Contents are deliberately not reset so a program survives a core reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sodor_imem_feed_ctrl.sv
// Replays a loaded program buffer into the sodor5 imem response path, repeating
// it a set number of passes, then drains the pipeline with NOPs and flags done.
module sodor_imem_feed_ctrl #(
    parameter int unsigned       DEPTH        = 16,
    parameter int unsigned       ADDR_W       = sodor_feed_pkg::ADDR_W,
    parameter int unsigned       WORD_W       = sodor_feed_pkg::WORD_W,
    parameter int unsigned       DRAIN_CYCLES = 5,
    parameter logic [WORD_W-1:0] NOP_WORD     = sodor_feed_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic [7:0]        loop_cnt,
    input  logic              start,
    input  logic              abort,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_idx,
    output logic              busy,
    output logic              done,
    output logic [15:0]       retired_cnt
);

    import sodor_feed_pkg::*;

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state_q;
    logic [WORD_W-1:0]  instr_q;
    logic               valid_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  last_q;
    logic [7:0]         loops_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               busy_q;
    logic               done_q;
    logic [15:0]        retired_q;

    logic               xfer;
    logic               len_ok;
    logic               wr_en;
    logic [ADDR_W-1:0]  rd_addr_d;
    logic [WORD_W-1:0]  rd_data;

    assign xfer   = valid_q & instr_ready;
    assign len_ok = (prog_len != '0) && (32'(prog_len) <= DEPTH);
    assign wr_en  = prog_we & ~busy_q & ~start;

    // Single read port: it always points at the word the next edge may load,
    // which is either the successor of pc_q or the wrap/start index 0.
    always_comb begin
        rd_addr_d = '0;
        if (state_q == FEED && pc_q != last_q) begin
            rd_addr_d = pc_q + ADDR_W'(1);
        end
    end

    sodor_feed_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr_d),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            instr_q   <= NOP_WORD;
            valid_q   <= 1'b0;
            pc_q      <= '0;
            last_q    <= '0;
            loops_q   <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start && len_ok) begin
                        state_q   <= FEED;
                        last_q    <= ADDR_W'(prog_len - 1'b1);
                        loops_q   <= (loop_cnt == '0) ? 8'd1 : loop_cnt;
                        pc_q      <= '0;
                        instr_q   <= rd_data;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        retired_q <= '0;
                    end
                end
                FEED: begin
                    if (xfer && retired_q != '1) begin
                        retired_q <= retired_q + 16'd1;
                    end
                    if (abort) begin
                        state_q <= DRAIN;
                        instr_q <= NOP_WORD;
                        drain_q <= '0;
                    end else if (xfer) begin
                        if (pc_q != last_q) begin
                            pc_q    <= pc_q + ADDR_W'(1);
                            instr_q <= rd_data;
                        end else if (loops_q > 8'd1) begin
                            pc_q    <= '0;
                            instr_q <= rd_data;
                            loops_q <= loops_q - 8'd1;
                        end else begin
                            state_q <= DRAIN;
                            instr_q <= NOP_WORD;
                            drain_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + DRAIN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_idx      = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_sodor_imem_feed_ctrl.sv
// Directed, table-driven bench for sodor_imem_feed_ctrl with hand-computed expectations.
module tb_sodor_imem_feed_ctrl;

    localparam logic [31:0] W_A = 32'h0010_0093;
    localparam logic [31:0] W_B = 32'h0020_0113;
    localparam logic [31:0] W_C = 32'h0030_8193;
    localparam logic [31:0] W_N = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
    logic [4:0]  prog_len;
    logic [7:0]  loop_cnt;
    logic        start;
    logic        abort;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic [3:0]  pc_idx;
    logic        busy;
    logic        done;
    logic [15:0] retired_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sodor_imem_feed_ctrl #(
        .DEPTH        (16),
        .ADDR_W       (4),
        .WORD_W       (32),
        .DRAIN_CYCLES (5),
        .NOP_WORD     (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .loop_cnt    (loop_cnt),
        .start       (start),
        .abort       (abort),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_idx      (pc_idx),
        .busy        (busy),
        .done        (done),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [4:0]  len;
        logic [7:0]  lp;
        logic        rdy;
        logic        ab;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [3:0]  e_pc;
        logic        pc_chk;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [4:0] len, input logic [7:0] lp,
                       input logic rdy, input logic ab, input logic [31:0] e_instr,
                       input logic e_valid, input logic [3:0] e_pc, input logic pc_chk,
                       input logic e_busy, input logic e_done, input logic [15:0] e_ret);
        vec_t v;
        v.st = st; v.len = len; v.lp = lp; v.rdy = rdy; v.ab = ab;
        v.e_instr = e_instr; v.e_valid = e_valid; v.e_pc = e_pc; v.pc_chk = pc_chk;
        v.e_busy = e_busy; v.e_done = e_done; v.e_ret = e_ret;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick;
        prog_we = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick;
            k++;
        end
        chk(nm, k, 32'(done), 32'd1);
    endtask

    // Start a 3-word single pass and check A, B, C appear in order, then done.
    task automatic run_prog(input string nm);
        start = 1'b1; prog_len = 5'd3; loop_cnt = 8'd1; instr_ready = 1'b1; abort = 1'b0;
        tick;
        start = 1'b0;
        chk({nm, " w0"}, 0, instr, W_A);
        chk({nm, " pc0"}, 0, 32'(pc_idx), 32'd0);
        tick;
        chk({nm, " w1"}, 1, instr, W_B);
        chk({nm, " pc1"}, 1, 32'(pc_idx), 32'd1);
        tick;
        chk({nm, " w2"}, 2, instr, W_C);
        chk({nm, " pc2"}, 2, 32'(pc_idx), 32'd2);
        wait_done({nm, " done"});
        chk({nm, " retired"}, 0, 32'(retired_cnt), 32'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; loop_cnt = '0; start = 1'b0; abort = 1'b0; instr_ready = 1'b1;

        // Test 1: 3 words, 1 pass
        add(1, 3, 1, 1, 0, W_A, 1, 0, 1, 1, 0, 0);
        add(0, 3, 1, 1, 0, W_B, 1, 1, 1, 1, 0, 1);
        add(0, 3, 1, 1, 0, W_C, 1, 2, 1, 1, 0, 2);
        for (int i = 0; i < 5; i++) add(0, 3, 1, 1, 0, W_N, 1, 0, 0, 1, 0, 3);
        add(0, 3, 1, 1, 0, W_N, 0, 0, 0, 0, 1, 3);
        // Test 2: 4 stall cycles while word 1 is presented
        add(1, 3, 1, 1, 0, W_A, 1, 0, 1, 1, 0, 0);
        add(0, 3, 1, 1, 0, W_B, 1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 3, 1, 0, 0, W_B, 1, 1, 1, 1, 0, 1);
        add(0, 3, 1, 1, 0, W_C, 1, 2, 1, 1, 0, 2);
        for (int i = 0; i < 5; i++) add(0, 3, 1, 1, 0, W_N, 1, 0, 0, 1, 0, 3);
        add(0, 3, 1, 1, 0, W_N, 0, 0, 0, 0, 1, 3);
        // Test 3: 2 words, 2 passes
        add(1, 2, 2, 1, 0, W_A, 1, 0, 1, 1, 0, 0);
        add(0, 2, 2, 1, 0, W_B, 1, 1, 1, 1, 0, 1);
        add(0, 2, 2, 1, 0, W_A, 1, 0, 1, 1, 0, 2);
        add(0, 2, 2, 1, 0, W_B, 1, 1, 1, 1, 0, 3);
        for (int i = 0; i < 5; i++) add(0, 2, 2, 1, 0, W_N, 1, 0, 0, 1, 0, 4);
        add(0, 2, 2, 1, 0, W_N, 0, 0, 0, 0, 1, 4);
        // loop_cnt=0 runs a single pass
        add(1, 2, 0, 1, 0, W_A, 1, 0, 1, 1, 0, 0);
        add(0, 2, 0, 1, 0, W_B, 1, 1, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 2, 0, 1, 0, W_N, 1, 0, 0, 1, 0, 2);
        add(0, 2, 0, 1, 0, W_N, 0, 0, 0, 0, 1, 2);
        // Test 4: 16 words, abort while word 1 transfers; abort ignored in DRAIN
        add(1, 16, 1, 1, 0, W_A, 1, 0, 1, 1, 0, 0);
        add(0, 16, 1, 1, 0, W_B, 1, 1, 1, 1, 0, 1);
        add(0, 16, 1, 1, 1, W_N, 1, 0, 0, 1, 0, 2);
        add(0, 16, 1, 1, 1, W_N, 1, 0, 0, 1, 0, 2);
        for (int i = 0; i < 3; i++) add(0, 16, 1, 1, 0, W_N, 1, 0, 0, 1, 0, 2);
        add(0, 16, 1, 1, 0, W_N, 0, 0, 0, 0, 1, 2);
        // Illegal lengths and abort in DONE change nothing
        add(1, 0, 1, 1, 0, W_N, 0, 0, 0, 0, 1, 2);
        add(1, 17, 1, 1, 1, W_N, 0, 0, 0, 0, 1, 2);
        add(0, 3, 1, 1, 1, W_N, 0, 0, 0, 0, 1, 2);

        tick;
        tick;
        chk("rst instr", 0, instr, W_N);
        chk("rst valid", 0, 32'(instr_valid), 32'd0);
        chk("rst pc", 0, 32'(pc_idx), 32'd0);
        chk("rst busy", 0, 32'(busy), 32'd0);
        chk("rst done", 0, 32'(done), 32'd0);
        chk("rst retired", 0, 32'(retired_cnt), 32'd0);
        reset = 1'b0;

        load(4'd0, W_A);
        load(4'd1, W_B);
        load(4'd2, W_C);
        for (int i = 3; i < 16; i++) load(4'(i), (32'(i) << 20) | 32'h13);

        foreach (vecs[i]) begin
            start = vecs[i].st; prog_len = vecs[i].len; loop_cnt = vecs[i].lp;
            instr_ready = vecs[i].rdy; abort = vecs[i].ab;
            tick;
            chk("vec instr", i, instr, vecs[i].e_instr);
            chk("vec valid", i, 32'(instr_valid), 32'(vecs[i].e_valid));
            chk("vec busy", i, 32'(busy), 32'(vecs[i].e_busy));
            chk("vec done", i, 32'(done), 32'(vecs[i].e_done));
            chk("vec retired", i, 32'(retired_cnt), 32'(vecs[i].e_ret));
            if (vecs[i].pc_chk) chk("vec pc", i, 32'(pc_idx), 32'(vecs[i].e_pc));
        end
        start = 1'b0; abort = 1'b0; instr_ready = 1'b1;

        // Test 5: asynchronous reset in the middle of FEED
        start = 1'b1; prog_len = 5'd3; loop_cnt = 8'd1;
        tick;
        start = 1'b0;
        tick;
        chk("t5 pre instr", 0, instr, W_B);
        chk("t5 pre busy", 0, 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5 async instr", 0, instr, W_N);
        chk("t5 async valid", 0, 32'(instr_valid), 32'd0);
        chk("t5 async busy", 0, 32'(busy), 32'd0);
        chk("t5 async retired", 0, 32'(retired_cnt), 32'd0);
        chk("t5 async pc", 0, 32'(pc_idx), 32'd0);
        reset = 1'b0;
        tick;
        chk("t5 post valid", 0, 32'(instr_valid), 32'd0);
        // start with prog_len=0 from IDLE is ignored
        start = 1'b1; prog_len = 5'd0;
        tick;
        start = 1'b0;
        chk("t6 len0 valid", 0, 32'(instr_valid), 32'd0);
        chk("t6 len0 busy", 0, 32'(busy), 32'd0);
        chk("t6 len0 done", 0, 32'(done), 32'd0);
        run_prog("t5 rerun");

        // Test 6: writes coincident with start or while busy are dropped
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 32'hDEAD_BEEF;
        start = 1'b1; prog_len = 5'd3; loop_cnt = 8'd1;
        tick;
        start = 1'b0; prog_addr = 4'd0;
        chk("t6 busy w0", 0, instr, W_A);
        tick;
        chk("t6 busy w1", 1, instr, W_B);
        tick;
        prog_we = 1'b0;
        wait_done("t6 first done");
        run_prog("t6 rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
